uart_fifo_ng: RTL

- Parametrised successor to the fixed 8N1 UART used in the chip testbench and SoC peripheral path.
- Adds runtime-selectable parity and stop bits, configurable data width and oversampling, independent TX and RX FIFOs with valid/ready handshakes, and sticky error flags.
- Sits between the SoC peripheral bus adapter (or the testbench echo logic) and the txd/rxd pins.

---
 rtl/uart_ng_pkg.sv | 26 ++
 rtl/uart_ng_fifo.sv | 54 +++++
 rtl/uart_fifo_ng.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_ng_pkg.sv
// Shared types for the uart_fifo_ng UART: parity modes, frame FSM states and
// the RX FIFO entry layout.
package uart_ng_pkg;

  localparam int MAX_DATA_BITS = 8;

  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;

  typedef struct packed {
    logic                     frame_err;
    logic                     parity_err;
    logic [MAX_DATA_BITS-1:0] data;
  } rx_entry_t;

  // Mode 3 is an alias of "none".
  function automatic parity_e decode_parity(input logic [1:0] mode);
    case (mode)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_ng_fifo.sv
// Synchronous FIFO used for both the TX and RX queues. A push into a full FIFO
// is accepted only when a pop frees the head slot in the same cycle.
module uart_ng_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  // Top bit of each pointer is the wrap bit; the low AW bits index storage.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_fifo_ng.sv
// Parametrised UART with runtime parity/stop selection, TX and RX FIFOs with
// valid/ready handshakes, per-character error flags and a sticky overrun flag.
module uart_fifo_ng
  import uart_ng_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DIV_W-1:0]             baud,
  input  logic [1:0]                   parity_mode,
  input  logic                         two_stop,
  input  logic                         clr_err,
  input  logic                         rx,
  output logic                         tx,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  input  logic [DATA_BITS-1:0]         tx_data,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic [DATA_BITS-1:0]         rx_data,
  output logic                         rx_parity_err,
  output logic                         rx_frame_err,
  output logic                         rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0]  tx_level,
  output logic [$clog2(FIFO_DEPTH):0]  rx_level,
  output logic                         busy
);

  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d, baud_last;
  logic             tick;

  uart_state_e          tx_state_q, tx_state_d;
  logic [OS_W-1:0]      tx_tick_q, tx_tick_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  parity_e              tx_parity_q, tx_parity_d;
  logic                 tx_two_q, tx_two_d, tx_pbit_q, tx_pbit_d, tx_q, tx_d;
  logic                 tx_push, tx_pop, tx_full, tx_empty, tx_start, tx_end;
  logic [DATA_BITS-1:0] tx_head;
  parity_e              cfg_parity;

  logic                 rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
  uart_state_e          rx_state_q, rx_state_d;
  logic [OS_W-1:0]      rx_tick_q, rx_tick_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  parity_e              rx_parity_q, rx_parity_d;
  logic                 rx_perr_q, rx_perr_d, rx_overrun_q, rx_overrun_d;
  logic                 rx_push, rx_pop, rx_full, rx_empty;
  rx_entry_t            rx_wr_entry, rx_head;

  // A divisor of 0 behaves like 1, so the tick fires every cycle.
  always_comb begin
    baud_last  = (baud == '0) ? '0 : baud - DIV_W'(1);
    tick       = (baud_cnt_q >= baud_last);
    baud_cnt_d = tick ? '0 : baud_cnt_q + DIV_W'(1);
  end

  assign tx_ready   = !tx_full;
  assign tx_push    = tx_valid && tx_ready;
  assign cfg_parity = decode_parity(parity_mode);

  uart_ng_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .wdata(tx_data), .pop(tx_pop),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_tick_d   = tx_tick_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_parity_d = tx_parity_q;
    tx_two_d    = tx_two_q;
    tx_pbit_d   = tx_pbit_q;
    tx_d        = tx_q;
    tx_pop      = 1'b0;
    tx_start    = 1'b0;
    tx_end      = tick && (tx_tick_q == OS_LAST);
    if (tick && tx_state_q != IDLE) tx_tick_d = (tx_tick_q == OS_LAST) ? '0 : tx_tick_q + OS_W'(1);
    case (tx_state_q)
      IDLE:  tx_start = tick && !tx_empty;
      START: if (tx_end) begin
        tx_state_d = DATA;
        tx_bit_d   = '0;
        tx_d       = tx_shift_q[0];
        tx_shift_d = tx_shift_q >> 1;
      end
      DATA: if (tx_end) begin
        if (tx_bit_q == BIT_LAST) begin
          tx_bit_d = '0;
          if (tx_parity_q != PAR_NONE) begin
            tx_state_d = PARITY;
            tx_d       = tx_pbit_q;
          end else begin
            tx_state_d = STOP;
            tx_d       = 1'b1;
          end
        end else begin
          tx_bit_d   = tx_bit_q + BIT_W'(1);
          tx_d       = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
        end
      end
      PARITY: if (tx_end) begin
        tx_state_d = STOP;
        tx_bit_d   = '0;
        tx_d       = 1'b1;
      end
      STOP: if (tx_end) begin
        if (tx_two_q && tx_bit_q == '0) tx_bit_d = BIT_W'(1);
        else if (!tx_empty)             tx_start = 1'b1;
        else                            tx_state_d = IDLE;
      end
      default: tx_state_d = IDLE;
    endcase
    // Frame start latches the character and the line configuration for the whole frame.
    if (tx_start) begin
      tx_pop      = 1'b1;
      tx_state_d  = START;
      tx_tick_d   = '0;
      tx_d        = 1'b0;
      tx_shift_d  = tx_head;
      tx_parity_d = cfg_parity;
      tx_two_d    = two_stop;
      tx_pbit_d   = (^tx_head) ^ (cfg_parity == PAR_ODD);
    end
  end

  assign rx_meta_d = rx;
  assign rx_sync_d = rx_meta_q;
  assign rx_prev_d = rx_sync_q;

  // After a zero stop sample, prev/sync stay low, so a new start needs the line to rise first.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_tick_d   = rx_tick_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_parity_d = rx_parity_q;
    rx_perr_d   = rx_perr_q;
    rx_push     = 1'b0;
    rx_wr_entry.data       = MAX_DATA_BITS'(rx_shift_q);
    rx_wr_entry.parity_err = rx_perr_q;
    rx_wr_entry.frame_err  = !rx_sync_q;
    if (tick && rx_state_q != IDLE) rx_tick_d = (rx_tick_q == OS_LAST) ? '0 : rx_tick_q + OS_W'(1);
    case (rx_state_q)
      IDLE: if (rx_prev_q && !rx_sync_q) begin
        rx_state_d  = START;
        rx_tick_d   = '0;
        rx_parity_d = cfg_parity;
        rx_perr_d   = 1'b0;
      end
      START: if (tick && rx_tick_q == OS_HALF) begin
        rx_tick_d = '0;
        rx_bit_d  = '0;
        if (rx_sync_q) rx_state_d = IDLE;
        else           rx_state_d = DATA;
      end
      DATA: if (tick && rx_tick_q == OS_LAST) begin
        rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
        rx_bit_d   = rx_bit_q + BIT_W'(1);
        if (rx_bit_q == BIT_LAST) begin
          if (rx_parity_q == PAR_NONE) rx_state_d = STOP;
          else                         rx_state_d = PARITY;
        end
      end
      PARITY: if (tick && rx_tick_q == OS_LAST) begin
        rx_perr_d  = rx_sync_q ^ (^rx_shift_q) ^ (rx_parity_q == PAR_ODD);
        rx_state_d = STOP;
      end
      STOP: if (tick && rx_tick_q == OS_LAST) begin
        rx_push    = 1'b1;
        rx_state_d = IDLE;
      end
      default: rx_state_d = IDLE;
    endcase
  end

  assign rx_pop = rx_valid && rx_ready;

  uart_ng_fifo #(.WIDTH($bits(rx_entry_t)), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .wdata(rx_wr_entry), .pop(rx_pop),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  // A dropped character outranks a same-cycle clear.
  always_comb begin
    rx_overrun_d = rx_overrun_q;
    if (clr_err) rx_overrun_d = 1'b0;
    if (rx_push && rx_full && !rx_pop) rx_overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt_q   <= '0;
      tx_state_q   <= IDLE;
      tx_tick_q    <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_parity_q  <= PAR_NONE;
      tx_two_q     <= 1'b0;
      tx_pbit_q    <= 1'b0;
      tx_q         <= 1'b1;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= IDLE;
      rx_tick_q    <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_parity_q  <= PAR_NONE;
      rx_perr_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      baud_cnt_q   <= baud_cnt_d;
      tx_state_q   <= tx_state_d;
      tx_tick_q    <= tx_tick_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_parity_q  <= tx_parity_d;
      tx_two_q     <= tx_two_d;
      tx_pbit_q    <= tx_pbit_d;
      tx_q         <= tx_d;
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      rx_state_q   <= rx_state_d;
      rx_tick_q    <= rx_tick_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_parity_q  <= rx_parity_d;
      rx_perr_q    <= rx_perr_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  assign tx            = tx_q;
  assign rx_valid      = !rx_empty;
  assign rx_data       = rx_head.data[DATA_BITS-1:0];
  assign rx_parity_err = rx_head.parity_err;
  assign rx_frame_err  = rx_head.frame_err;
  assign rx_overrun    = rx_overrun_q;
  assign busy          = (tx_state_q != IDLE) || !tx_empty;

endmodule
